// File: rtl/mem_arbiter.sv
// Shared-memory arbiter: serialises I-cache fills, D-cache fills and D-cache
// write-through stores onto the single multicycle memory port.
module mem_arbiter #(
  parameter int MEM_LAT = 4,
  parameter int WORDS   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ic_req,
  input  logic [15:0] ic_addr,
  input  logic        dc_req,
  input  logic [15:0] dc_addr,
  input  logic        dc_wr,
  input  logic [15:0] dc_wr_addr,
  input  logic [15:0] dc_wr_data,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        ic_fill_valid,
  output logic        dc_fill_valid,
  output logic        ic_done,
  output logic        dc_done,
  output logic        wr_ack,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  output logic        mem_enable,
  output logic        mem_wr,
  input  logic [15:0] mem_data_out,
  input  logic        mem_data_valid
);

  // state   | meaning
  // IDLE    | arbitrate: store first, then round-robin between fills
  // FILL_IC | issue 8 reads, steer returned words to the I-cache
  // FILL_DC | issue 8 reads, steer returned words to the D-cache
  // WRITE   | single-cycle write-through store
  typedef enum logic [1:0] {IDLE, FILL_IC, FILL_DC, WRITE} state_t;

  // Counter widths and the 2-byte address step assume 8-word lines; memory
  // latency only shapes when returns arrive, the FSM just counts them.
  if (WORDS != 8 || MEM_LAT < 1) begin : g_bad_params
    $error("mem_arbiter: unsupported WORDS/MEM_LAT");
  end

  state_t      state, state_nxt;
  logic [15:0] base, base_nxt;
  logic [3:0]  issue_cnt, issue_nxt;
  logic [2:0]  ret_cnt, ret_nxt;
  logic        rr_ic, rr_nxt;
  logic        in_fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      base      <= 16'h0000;
      issue_cnt <= 4'd0;
      ret_cnt   <= 3'd0;
      rr_ic     <= 1'b0;
    end else begin
      state     <= state_nxt;
      base      <= base_nxt;
      issue_cnt <= issue_nxt;
      ret_cnt   <= ret_nxt;
      rr_ic     <= rr_nxt;
    end
  end

  assign in_fill = (state == FILL_IC) || (state == FILL_DC);

  always_comb begin
    state_nxt     = state;
    base_nxt      = base;
    issue_nxt     = issue_cnt;
    ret_nxt       = ret_cnt;
    rr_nxt        = rr_ic;
    fill_data     = 16'h0000;
    fill_word     = 3'd0;
    ic_fill_valid = 1'b0;
    dc_fill_valid = 1'b0;
    ic_done       = 1'b0;
    dc_done       = 1'b0;
    wr_ack        = 1'b0;
    mem_addr      = 16'h0000;
    mem_data_in   = 16'h0000;
    mem_enable    = 1'b0;
    mem_wr        = 1'b0;

    case (state)
      IDLE: begin
        if (dc_wr) begin
          state_nxt = WRITE;
        end else if (ic_req && (!dc_req || rr_ic)) begin
          state_nxt = FILL_IC;
          base_nxt  = ic_addr & 16'hFFF0;
          issue_nxt = 4'd0;
          ret_nxt   = 3'd0;
        end else if (dc_req) begin
          state_nxt = FILL_DC;
          base_nxt  = dc_addr & 16'hFFF0;
          issue_nxt = 4'd0;
          ret_nxt   = 3'd0;
        end
      end
      WRITE: begin
        mem_enable  = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = dc_wr_addr;
        mem_data_in = dc_wr_data;
        wr_ack      = 1'b1;
        state_nxt   = IDLE;
      end
      default: begin
        if (issue_cnt < 4'(WORDS)) begin
          mem_enable = 1'b1;
          mem_addr   = base + {11'd0, issue_cnt, 1'b0};
          issue_nxt  = issue_cnt + 4'd1;
        end
        if (in_fill && mem_data_valid) begin
          fill_data     = mem_data_out;
          fill_word     = ret_cnt;
          ic_fill_valid = (state == FILL_IC);
          dc_fill_valid = (state == FILL_DC);
          ret_nxt       = ret_cnt + 3'd1;
          if (ret_cnt == 3'(WORDS - 1)) begin
            ic_done   = (state == FILL_IC);
            dc_done   = (state == FILL_DC);
            state_nxt = IDLE;
            rr_nxt    = ~rr_ic;
          end
        end
      end
    endcase
  end

endmodule
